// File: rtl/implication_checker.sv
// implication_checker: per-channel bounded-response checker for
// "antecedent |-> ##[MIN_DLY:MAX_DLY] consequent".
// Each channel runs a two-state FSM (IDLE/WAIT) with an age counter, emits
// registered pass/fail pulses, and keeps saturating pass/fail statistics.
// Optional concurrent assertions/covers are compiled only when the macro
// IMPLICATION_CHECKER_SVA_EN is defined; port behaviour is identical either way.
module implication_checker #(
  parameter int NUM_CH  = 4,
  parameter int MIN_DLY = 0,
  parameter int MAX_DLY = 1,
  parameter int STRICT  = 0,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       antecedent,
  input  logic [NUM_CH-1:0]       consequent,
  output logic [NUM_CH-1:0]       pass,
  output logic [NUM_CH-1:0]       fail,
  output logic [NUM_CH-1:0]       busy,
  output logic                    fail_any,
  output logic [NUM_CH*CNT_W-1:0] pass_cnt,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt
);

  localparam int AGE_W = (MAX_DLY > 0) ? $clog2(MAX_DLY + 1) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [AGE_W-1:0]   age_q   [NUM_CH];
  logic [AGE_W-1:0]   age_d   [NUM_CH];
  logic [NUM_CH-1:0]  pass_q, pass_d;
  logic [NUM_CH-1:0]  fail_q, fail_d;
  logic               fail_any_q, fail_any_d;
  logic [CNT_W-1:0]   pcnt_q  [NUM_CH];
  logic [CNT_W-1:0]   pcnt_d  [NUM_CH];
  logic [CNT_W-1:0]   fcnt_q  [NUM_CH];
  logic [CNT_W-1:0]   fcnt_d  [NUM_CH];

  // Next-state and resolution logic for every channel FSM.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would otherwise infer a latch.
      state_d[i] = state_q[i];
      age_d[i]   = age_q[i];
      pass_d[i]  = 1'b0;
      fail_d[i]  = 1'b0;
      if (!en) begin
        // Disabling drops any pending obligation silently.
        state_d[i] = ST_IDLE;
        age_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (antecedent[i]) begin
              if ((MIN_DLY == 0) && consequent[i]) begin
                pass_d[i] = 1'b1;
              end else if (MAX_DLY == 0) begin
                fail_d[i] = 1'b1;
              end else begin
                state_d[i] = ST_WAIT;
                age_d[i]   = AGE_W'(1);
              end
            end
          end
          ST_WAIT: begin
            // Antecedent is deliberately ignored here, even when resolving.
            if (consequent[i] && (int'(age_q[i]) >= MIN_DLY)) begin
              pass_d[i]  = 1'b1;
              state_d[i] = ST_IDLE;
              age_d[i]   = '0;
            end else if (consequent[i] && (STRICT != 0)) begin
              // Early consequent in strict mode.
              fail_d[i]  = 1'b1;
              state_d[i] = ST_IDLE;
              age_d[i]   = '0;
            end else if (int'(age_q[i]) == MAX_DLY) begin
              fail_d[i]  = 1'b1;
              state_d[i] = ST_IDLE;
              age_d[i]   = '0;
            end else begin
              age_d[i] = age_q[i] + AGE_W'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            age_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Saturating statistics and sticky fail flag; clr wins over increments.
  always_comb begin
    fail_any_d = clr ? 1'b0 : (fail_any_q | (|fail_d));
    for (int i = 0; i < NUM_CH; i++) begin
      pcnt_d[i] = pcnt_q[i];
      fcnt_d[i] = fcnt_q[i];
      if (clr) begin
        pcnt_d[i] = '0;
        fcnt_d[i] = '0;
      end else begin
        if (pass_d[i] && (pcnt_q[i] != '1)) pcnt_d[i] = pcnt_q[i] + CNT_W'(1);
        if (fail_d[i] && (fcnt_q[i] != '1)) fcnt_d[i] = fcnt_q[i] + CNT_W'(1);
      end
    end
  end

  // State, pulse and statistics registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_q     <= '0;
      fail_q     <= '0;
      fail_any_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        age_q[i]   <= '0;
        pcnt_q[i]  <= '0;
        fcnt_q[i]  <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      fail_any_q <= fail_any_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        age_q[i]   <= age_d[i];
        pcnt_q[i]  <= pcnt_d[i];
        fcnt_q[i]  <= fcnt_d[i];
      end
    end
  end

  // Output mapping: busy mirrors WAIT, counters are packed channel by channel.
  always_comb begin
    busy     = '0;
    pass_cnt = '0;
    fail_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i]                       = (state_q[i] == ST_WAIT);
      pass_cnt[i*CNT_W +: CNT_W]    = pcnt_q[i];
      fail_cnt[i*CNT_W +: CNT_W]    = fcnt_q[i];
    end
  end

  assign pass     = pass_q;
  assign fail     = fail_q;
  assign fail_any = fail_any_q;

`ifdef IMPLICATION_CHECKER_SVA_EN
  for (genvar g = 0; g < NUM_CH; g++) begin : g_sva
    property p_impl;
      @(posedge clk) disable iff (!rst_n || !en)
        antecedent[g] |-> ##[MIN_DLY:MAX_DLY] consequent[g];
    endproperty

    property p_excl;
      @(posedge clk) disable iff (!rst_n)
        !(pass[g] && fail[g]);
    endproperty

    a_impl : assert property (p_impl);
    c_impl : cover property (@(posedge clk) disable iff (!rst_n || !en)
                             antecedent[g] ##[MIN_DLY:MAX_DLY] consequent[g]);
    a_excl : assert property (p_excl);
  end
`else
  // Assertions compiled out; behaviour unchanged.
`endif

endmodule

// File: tb/tb_implication_checker.sv
// Testbench for implication_checker: five instances with different window
// settings share one stimulus stream; a timestamp-based reference model
// predicts every output of every instance.
module tb_implication_checker;

  localparam int NI = 5;
  // Per-instance settings: a=overlap/CNT_W2, b=1..3, c=2..4 strict,
  // d=2..4 lenient, e=non-overlapping.
  localparam int MIN_T [NI] = '{0, 1, 2, 2, 1};
  localparam int MAX_T [NI] = '{0, 3, 4, 4, 1};
  localparam int STR_T [NI] = '{0, 0, 1, 0, 0};
  localparam int CW_T  [NI] = '{2, 16, 16, 16, 8};

  logic       clk = 1'b0;
  logic       rst_n, en, clr;
  logic [3:0] ant, con;

  logic [3:0]  pass_w [NI];
  logic [3:0]  fail_w [NI];
  logic [3:0]  busy_w [NI];
  logic        fany_w [NI];
  logic [63:0] pcnt_w [NI];
  logic [63:0] fcnt_w [NI];
  logic [7:0]  pc_a, fc_a;
  logic [31:0] pc_e, fc_e;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  implication_checker #(.NUM_CH(4), .MIN_DLY(0), .MAX_DLY(0), .STRICT(0), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .antecedent(ant), .consequent(con),
    .pass(pass_w[0]), .fail(fail_w[0]), .busy(busy_w[0]), .fail_any(fany_w[0]),
    .pass_cnt(pc_a), .fail_cnt(fc_a));
  implication_checker #(.NUM_CH(4), .MIN_DLY(1), .MAX_DLY(3), .STRICT(0), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .antecedent(ant), .consequent(con),
    .pass(pass_w[1]), .fail(fail_w[1]), .busy(busy_w[1]), .fail_any(fany_w[1]),
    .pass_cnt(pcnt_w[1]), .fail_cnt(fcnt_w[1]));
  implication_checker #(.NUM_CH(4), .MIN_DLY(2), .MAX_DLY(4), .STRICT(1), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .antecedent(ant), .consequent(con),
    .pass(pass_w[2]), .fail(fail_w[2]), .busy(busy_w[2]), .fail_any(fany_w[2]),
    .pass_cnt(pcnt_w[2]), .fail_cnt(fcnt_w[2]));
  implication_checker #(.NUM_CH(4), .MIN_DLY(2), .MAX_DLY(4), .STRICT(0), .CNT_W(16)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .antecedent(ant), .consequent(con),
    .pass(pass_w[3]), .fail(fail_w[3]), .busy(busy_w[3]), .fail_any(fany_w[3]),
    .pass_cnt(pcnt_w[3]), .fail_cnt(fcnt_w[3]));
  implication_checker #(.NUM_CH(4), .MIN_DLY(1), .MAX_DLY(1), .STRICT(0), .CNT_W(8)) u_e (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .antecedent(ant), .consequent(con),
    .pass(pass_w[4]), .fail(fail_w[4]), .busy(busy_w[4]), .fail_any(fany_w[4]),
    .pass_cnt(pc_e), .fail_cnt(fc_e));

  assign pcnt_w[0] = 64'(pc_a);
  assign fcnt_w[0] = 64'(fc_a);
  assign pcnt_w[4] = 64'(pc_e);
  assign fcnt_w[4] = 64'(fc_e);

  // Reference model: an obligation is a start timestamp; resolution is
  // decided from the elapsed cycle count against the window bounds.
  typedef struct {
    bit         pend  [4];
    int         start [4];
    bit [3:0]   pass;
    bit [3:0]   fail;
    bit [3:0]   busy;
    bit         fany;
    int         pcnt  [4];
    int         fcnt  [4];
  } model_t;

  model_t m [NI];

  function automatic model_t model_step(model_t s, int k, int now, bit r, bit e, bit cl,
                                        bit [3:0] a, bit [3:0] c);
    model_t n    = s;
    int     cmax = (1 << CW_T[k]) - 1;
    int     el;
    n.pass = '0;
    n.fail = '0;
    if (!r) begin
      for (int ch = 0; ch < 4; ch++) begin
        n.pend[ch] = 0; n.pcnt[ch] = 0; n.fcnt[ch] = 0;
      end
      n.busy = '0;
      n.fany = 0;
      return n;
    end
    for (int ch = 0; ch < 4; ch++) begin
      if (!e) begin
        n.pend[ch] = 0;
      end else if (s.pend[ch]) begin
        el = now - s.start[ch];
        if (c[ch] && el >= MIN_T[k])            begin n.pass[ch] = 1; n.pend[ch] = 0; end
        else if (c[ch] && STR_T[k] != 0)        begin n.fail[ch] = 1; n.pend[ch] = 0; end
        else if (el >= MAX_T[k])                begin n.fail[ch] = 1; n.pend[ch] = 0; end
      end else if (a[ch]) begin
        if (MIN_T[k] == 0 && c[ch])             n.pass[ch] = 1;
        else if (MAX_T[k] == 0)                 n.fail[ch] = 1;
        else begin n.pend[ch] = 1; n.start[ch] = now; end
      end
      n.busy[ch] = n.pend[ch];
    end
    if (cl) begin
      n.fany = 0;
      for (int ch = 0; ch < 4; ch++) begin n.pcnt[ch] = 0; n.fcnt[ch] = 0; end
    end else begin
      n.fany = s.fany | (|n.fail);
      for (int ch = 0; ch < 4; ch++) begin
        if (n.pass[ch] && n.pcnt[ch] < cmax) n.pcnt[ch]++;
        if (n.fail[ch] && n.fcnt[ch] < cmax) n.fcnt[ch]++;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] dut_cnt(logic [63:0] v, int w, int ch);
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    return 32'((v >> (ch * w)) & mask);
  endfunction

  // One clock: model consumes the inputs sampled at the edge; outputs are
  // then observed on the following falling edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NI; k++) m[k] = model_step(m[k], k, cyc, rst_n, en, clr, ant, con);
    cyc++;
    @(negedge clk);
  endtask

  task automatic quiesce();
    ant = '0; con = '0; en = 1'b1; clr = 1'b0; rst_n = 1'b1;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; ant = '1; con = '0;
    repeat (2) tick();
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if ({pass_w[k], fail_w[k], busy_w[k], fany_w[k]} !== 13'd0 ||
          pcnt_w[k] !== 64'd0 || fcnt_w[k] !== 64'd0) begin
        n_err++;
        $display("FAIL reset inst%0d: pass=%b fail=%b busy=%b fany=%b pc=%h fc=%h, want all 0",
                 k, pass_w[k], fail_w[k], busy_w[k], fany_w[k], pcnt_w[k], fcnt_w[k]);
      end
    end
    rst_n = 1'b1; ant = '0;
  endtask

  task automatic test_overlap();
    quiesce();
    ant = 4'b0001; con = 4'b0001;
    tick();
    ant = '0; con = '0;
    n_cmp++;
    if (pass_w[0] !== 4'b0001 || dut_cnt(pcnt_w[0], 2, 0) !== 32'd1) begin
      n_err++;
      $display("FAIL overlap: pass=%b cnt=%0d, want 0001 cnt=1", pass_w[0], dut_cnt(pcnt_w[0], 2, 0));
    end
    n_cmp++;
    if (busy_w[4] !== 4'b0001) begin
      n_err++;
      $display("FAIL nonoverlap_wait: busy=%b, want 0001", busy_w[4]);
    end
    tick();
    n_cmp++;
    if (fail_w[4] !== 4'b0001 || pass_w[4] !== 4'b0000) begin
      n_err++;
      $display("FAIL nonoverlap_fail: fail=%b pass=%b, want 0001/0000", fail_w[4], pass_w[4]);
    end
    ant = 4'b0001;
    tick();
    ant = '0; con = 4'b0001;
    tick();
    con = '0;
    n_cmp++;
    if (pass_w[4] !== 4'b0001) begin
      n_err++;
      $display("FAIL nonoverlap_pass: pass=%b, want 0001", pass_w[4]);
    end
  endtask

  task automatic test_window();
    quiesce();
    ant = 4'b0010;
    tick();
    ant = '0;
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (busy_w[1][1] !== 1'b1 || fail_w[1][1] !== 1'b0) begin
        n_err++;
        $display("FAIL window_busy step%0d: busy=%b fail=%b, want busy[1]=1 fail[1]=0",
                 j, busy_w[1], fail_w[1]);
      end
      tick();
    end
    n_cmp++;
    if (fail_w[1] !== 4'b0010 || busy_w[1] !== 4'b0000 || fany_w[1] !== 1'b1) begin
      n_err++;
      $display("FAIL window_timeout: fail=%b busy=%b fany=%b, want 0010/0000/1",
               fail_w[1], busy_w[1], fany_w[1]);
    end
    tick();
    n_cmp++;
    if (fail_w[1] !== 4'b0000 || fany_w[1] !== 1'b1) begin
      n_err++;
      $display("FAIL window_sticky: fail=%b fany=%b, want 0000/1", fail_w[1], fany_w[1]);
    end
  endtask

  task automatic test_strict();
    quiesce();
    ant = 4'b0001;
    tick();
    ant = '0; con = 4'b0001;
    tick();
    n_cmp++;
    if (fail_w[2] !== 4'b0001 || pass_w[2] !== 4'b0000) begin
      n_err++;
      $display("FAIL strict_early: fail=%b pass=%b, want 0001/0000", fail_w[2], pass_w[2]);
    end
    n_cmp++;
    if (busy_w[3] !== 4'b0001 || fail_w[3] !== 4'b0000 || pass_w[3] !== 4'b0000) begin
      n_err++;
      $display("FAIL lenient_early: busy=%b fail=%b pass=%b, want 0001/0000/0000",
               busy_w[3], fail_w[3], pass_w[3]);
    end
    con = '0;
    tick();
    con = 4'b0001;
    tick();
    con = '0;
    n_cmp++;
    if (pass_w[3] !== 4'b0001) begin
      n_err++;
      $display("FAIL lenient_pass: pass=%b, want 0001", pass_w[3]);
    end
  endtask

  task automatic test_back_to_back();
    quiesce();
    ant = 4'b0100;
    tick();
    tick();
    ant = '0; con = 4'b0100;
    tick();
    con = '0;
    n_cmp++;
    if (pass_w[1] !== 4'b0100 || dut_cnt(pcnt_w[1], 16, 2) !== 32'd1) begin
      n_err++;
      $display("FAIL b2b_pass: pass=%b cnt=%0d, want 0100 cnt=1", pass_w[1], dut_cnt(pcnt_w[1], 16, 2));
    end
    repeat (5) begin
      tick();
      n_cmp++;
      if (pass_w[1][2] !== 1'b0 || fail_w[1][2] !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_extra: pass=%b fail=%b, want bit2 clear", pass_w[1], fail_w[1]);
      end
    end
    // Reset in the middle of a pending obligation.
    quiesce();
    ant = 4'b1000;
    tick();
    ant = '0;
    n_cmp++;
    if (busy_w[1] !== 4'b1000) begin
      n_err++;
      $display("FAIL rst_wait_pre: busy=%b, want 1000", busy_w[1]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (busy_w[1] !== 4'b0000 || pass_w[1] !== 4'b0000 || fail_w[1] !== 4'b0000) begin
        n_err++;
        $display("FAIL rst_wait step%0d: busy=%b pass=%b fail=%b, want all 0",
                 j, busy_w[1], pass_w[1], fail_w[1]);
      end
      tick();
    end
  endtask

  task automatic test_enable();
    quiesce();
    ant = 4'b0001;
    tick();
    ant = '0; en = 1'b0; con = 4'b0001;
    tick();
    n_cmp++;
    if (busy_w[1] !== 4'b0000 || pass_w[1] !== 4'b0000 || fail_w[1] !== 4'b0000) begin
      n_err++;
      $display("FAIL disable_drop: busy=%b pass=%b fail=%b, want all 0", busy_w[1], pass_w[1], fail_w[1]);
    end
    ant = 4'b0001; con = '0;
    tick();
    ant = '0; en = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (dut_cnt(pcnt_w[1], 16, 0) !== 32'd0 || dut_cnt(fcnt_w[1], 16, 0) !== 32'd0 || fany_w[1] !== 1'b0) begin
      n_err++;
      $display("FAIL disable_hold: pc=%0d fc=%0d fany=%b, want 0/0/0",
               dut_cnt(pcnt_w[1], 16, 0), dut_cnt(fcnt_w[1], 16, 0), fany_w[1]);
    end
  endtask

  task automatic test_saturate();
    quiesce();
    ant = 4'b0001; con = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++;
      if (pass_w[0][0] !== 1'b1 || dut_cnt(pcnt_w[0], 2, 0) !== 32'((i < 3) ? i : 3)) begin
        n_err++;
        $display("FAIL saturate pass%0d: pass=%b cnt=%0d, want 1 cnt=%0d",
                 i, pass_w[0], dut_cnt(pcnt_w[0], 2, 0), (i < 3) ? i : 3);
      end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0; ant = '0; con = '0;
    n_cmp++;
    if (pass_w[0][0] !== 1'b1 || dut_cnt(pcnt_w[0], 2, 0) !== 32'd0) begin
      n_err++;
      $display("FAIL clr_priority: pass=%b cnt=%0d, want 1 cnt=0", pass_w[0], dut_cnt(pcnt_w[0], 2, 0));
    end
  endtask

  task automatic test_all_fail();
    quiesce();
    ant = 4'b1111; con = '0;
    tick();
    ant = '0;
    n_cmp++;
    if (fail_w[0] !== 4'b1111 || fany_w[0] !== 1'b1) begin
      n_err++;
      $display("FAIL all_fail: fail=%b fany=%b, want 1111/1", fail_w[0], fany_w[0]);
    end
    for (int ch = 0; ch < 4; ch++) begin
      n_cmp++;
      if (dut_cnt(fcnt_w[0], 2, ch) !== 32'd1) begin
        n_err++;
        $display("FAIL all_fail_cnt ch%0d: cnt=%0d, want 1", ch, dut_cnt(fcnt_w[0], 2, ch));
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 800; t++) begin
      ant   = 4'($urandom) & 4'($urandom);
      con   = 4'($urandom) & 4'($urandom);
      en    = ($urandom_range(0, 19) != 0);
      clr   = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if ({pass_w[k], fail_w[k], busy_w[k], fany_w[k]} !== {m[k].pass, m[k].fail, m[k].busy, m[k].fany}) begin
          n_err++;
          $display("FAIL random t%0d inst%0d: pass/fail/busy/fany=%b/%b/%b/%b, want %b/%b/%b/%b",
                   t, k, pass_w[k], fail_w[k], busy_w[k], fany_w[k],
                   m[k].pass, m[k].fail, m[k].busy, m[k].fany);
        end
        for (int ch = 0; ch < 4; ch++) begin
          n_cmp++;
          if (dut_cnt(pcnt_w[k], CW_T[k], ch) !== 32'(m[k].pcnt[ch]) ||
              dut_cnt(fcnt_w[k], CW_T[k], ch) !== 32'(m[k].fcnt[ch])) begin
            n_err++;
            $display("FAIL random_cnt t%0d inst%0d ch%0d: pc=%0d fc=%0d, want %0d/%0d",
                     t, k, ch, dut_cnt(pcnt_w[k], CW_T[k], ch), dut_cnt(fcnt_w[k], CW_T[k], ch),
                     m[k].pcnt[ch], m[k].fcnt[ch]);
          end
        end
      end
    end
    rst_n = 1'b1; en = 1'b1; clr = 1'b0; ant = '0; con = '0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; ant = '0; con = '0;
    test_reset();
    test_overlap();
    test_window();
    test_strict();
    test_back_to_back();
    test_enable();
    test_saturate();
    test_all_fail();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/implication_checker.md
IMPLICATION_CHECKER -- requirements
Module: implication_checker

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, the number of independent antecedent/consequent channels (1..32).
REQ-002 The block SHALL have parameter MIN_DLY, default 0, the earliest cycle after the antecedent at which the consequent is accepted.
REQ-003 The block SHALL have parameter MAX_DLY, default 1, the latest cycle after the antecedent at which the consequent is accepted (MIN_DLY <= MAX_DLY <= 255).
REQ-004 The block SHALL have parameter STRICT, default 0, where 1 means a consequent seen before MIN_DLY is a failure.
REQ-005 The block SHALL have parameter CNT_W, default 16, the width of each saturating statistics counter.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: the synchronous, active-low reset.
REQ-008 The block SHALL have port en, input, 1 bit: checking enable.
REQ-009 The block SHALL have port clr, input, 1 bit: clears the counters and the sticky flag.
REQ-010 The block SHALL have port antecedent, input, NUM_CH bits: per-channel trigger.
REQ-011 The block SHALL have port consequent, input, NUM_CH bits: per-channel expected response.
REQ-012 The block SHALL have port pass, output, NUM_CH bits: one-cycle pulse when an obligation is satisfied.
REQ-013 The block SHALL have port fail, output, NUM_CH bits: one-cycle pulse when an obligation is violated.
REQ-014 The block SHALL have port busy, output, NUM_CH bits: the channel holds a pending obligation.
REQ-015 The block SHALL have port fail_any, output, 1 bit: sticky OR of all fail pulses.
REQ-016 The block SHALL have ports pass_cnt and fail_cnt, output, NUM_CH*CNT_W bits each: per-channel saturating counts, with channel i at bits [i*CNT_W +: CNT_W].

Function
REQ-017 Each channel SHALL implement a two-state FSM with states IDLE and WAIT, plus an age counter of width clog2(MAX_DLY+1), min 1.
REQ-018 In IDLE with en=1 and antecedent=1, if MIN_DLY=0 and consequent=1 in the same cycle, the channel SHALL resolve pass and stay IDLE.
REQ-019 In IDLE with en=1 and antecedent=1, if MAX_DLY=0 and consequent=0, the channel SHALL resolve fail and stay IDLE.
REQ-020 In IDLE with en=1 and antecedent=1, in all other cases the channel SHALL enter WAIT with age=1.
REQ-021 In WAIT, for consequent=1 with age>=MIN_DLY, the channel SHALL resolve pass and go to IDLE.
REQ-022 In WAIT, for consequent=1 with age<MIN_DLY and STRICT=1, the channel SHALL resolve fail and go to IDLE.
REQ-023 In WAIT, for consequent=1 with age<MIN_DLY and STRICT=0, the channel SHALL ignore the consequent and stay in WAIT.
REQ-024 In WAIT, for no accepted consequent with age=MAX_DLY, the channel SHALL resolve fail and go to IDLE.
REQ-025 In WAIT, for no accepted consequent with age<MAX_DLY, the channel SHALL increment age and stay in WAIT.
REQ-026 The channel SHALL ignore antecedent while in WAIT, including in the resolving cycle; it SHALL re-arm no earlier than the next IDLE cycle.
REQ-027 The pass and fail outputs SHALL be registered and asserted in the cycle after the resolving cycle, for exactly one cycle; they SHALL never both be set on one channel.
REQ-028 The busy output SHALL be 1 exactly when the channel is in WAIT.
REQ-029 With MIN_DLY=MAX_DLY=0 the block SHALL check overlapping implication; with MIN_DLY=MAX_DLY=1 it SHALL check non-overlapping implication.
REQ-030 On each pass or fail pulse the corresponding counter SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-031 When en=0, all channels SHALL go to IDLE on the next edge, no pulses SHALL be generated, and counters and fail_any SHALL hold.
REQ-032 When clr=1, the counters and fail_any SHALL be set to 0; clr SHALL take priority over a same-cycle increment; the FSMs SHALL be unaffected.
REQ-033 The fail_any output SHALL be set in the cycle any fail bit is 1 and held until clr or reset.
REQ-034 Channels SHALL be fully independent; simultaneous events on different channels SHALL each be counted.

Reset
REQ-035 When rst_n=0 at a clk edge, all FSMs SHALL go to IDLE and age SHALL be set to 0.
REQ-036 When rst_n=0 at a clk edge, pass, fail, busy, fail_any, pass_cnt and fail_cnt SHALL all be set to 0.
REQ-037 A reset during WAIT SHALL drop the pending obligation with no pass or fail pulse.
REQ-038 Reset SHALL take priority over clr and en.

Configuration
REQ-039 With macro IMPLICATION_CHECKER_SVA_EN defined, the block SHALL compile per-channel concurrent assertions and covers of antecedent |-> ##[MIN_DLY:MAX_DLY] consequent, disabled while rst_n=0 or en=0.
REQ-040 With IMPLICATION_CHECKER_SVA_EN defined, the block SHALL compile an assertion that pass and fail are never both set on a channel.
REQ-041 Without IMPLICATION_CHECKER_SVA_EN, no SVA SHALL be compiled, and port behaviour SHALL be identical with or without the macro.

Verification
REQ-042 With MIN=MAX=0, ch0 antecedent=1 and consequent=1 in cycle 5 -> pass[0]=1 in cycle 6, pass_cnt[0]=1.
REQ-043 With MIN=1, MAX=3, ch1 antecedent in cycle 10 and no consequent -> busy[1] in cycles 11-13, fail[1]=1 in cycle 14, fail_any=1 from cycle 14.
REQ-044 With MIN=2, MAX=4, STRICT=1, antecedent in cycle 0 and consequent in cycle 1 -> fail=1 in cycle 2; with STRICT=0 and a second consequent in cycle 3 -> pass=1 in cycle 4.
REQ-045 A second antecedent arriving during WAIT -> only one pass or fail pulse; rst_n=0 in the middle of WAIT -> busy=0 and no pulse.
REQ-046 With CNT_W=2, apply 5 consecutive passes -> pass_cnt saturates at 3; clr=1 in the same cycle as a pass -> pass_cnt=0.
REQ-047 With all 4 channels failing in the same cycle -> fail=4'b1111, and each fail_cnt=1.
